// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration responder.
//   state_t        responder FSM states
//   BIT_ACK/NACK   value of SDA in the ninth (acknowledge) bit
//   DEV_ADDR_DEF   default 7-bit target address
//   DEVICE_ID_DEF  default read-only identifier served at register 0
package i2c_cfg_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACK_ADDR,
      ST_PTR,
      ST_ACK_PTR,
      ST_WR,
      ST_ACK_WR,
      ST_RD,
      ST_RD_ACK,
      ST_IGNORE
   } state_t;

   localparam logic       BIT_ACK       = 1'b0;
   localparam logic       BIT_NACK      = 1'b1;
   localparam logic [6:0] DEV_ADDR_DEF  = 7'h76;
   localparam logic [7:0] DEVICE_ID_DEF = 8'h17;

endpackage

// File: rtl/i2c_cfg_responder_bus_sync.sv
// Synchronizer and event detector for the I2C pins.
//   clk, reset           system clock, async active-high reset
//   scl_i, sda_i         raw bus pins
//   scl_rise, scl_fall   one-cycle SCL edge pulses
//   start_det, stop_det  one-cycle START / STOP pulses
//   sda_s                synchronized SDA, aligned with the event pulses
// All outputs are registered: an edge on the pins shows up DEGLITCH+1 clk later.
// DEGLITCH must be at least 2.
module i2c_bus_sync #(
   parameter int DEGLITCH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [DEGLITCH-1:0] scl_sync;
   logic [DEGLITCH-1:0] sda_sync;
   logic                scl_q;
   logic                sda_q;
   logic                scl_p;
   logic                sda_p;

   assign scl_q = scl_sync[DEGLITCH-1];
   assign sda_q = sda_sync[DEGLITCH-1];

   // Chains reset to the idle-bus level so release of reset never looks like an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync  <= '1;
         sda_sync  <= '1;
         scl_p     <= 1'b1;
         sda_p     <= 1'b1;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         sda_s     <= 1'b1;
      end else begin
         scl_sync  <= {scl_sync[DEGLITCH-2:0], scl_i};
         sda_sync  <= {sda_sync[DEGLITCH-2:0], sda_i};
         scl_p     <= scl_q;
         sda_p     <= sda_q;
         scl_rise  <= scl_q & ~scl_p;
         scl_fall  <= ~scl_q & scl_p;
         start_det <= scl_q & scl_p & sda_p & ~sda_q;
         stop_det  <= scl_q & scl_p & ~sda_p & sda_q;
         sda_s     <= sda_q;
      end
   end

endmodule

// File: rtl/i2c_cfg_responder.sv
// I2C target standing in for the DVI transmitter on the configuration bus.
//   clk, reset   system clock (>= 16x SCL), async active-high reset
//   scl_i, sda_i bus pins
//   sda_oe       1 = pull SDA low
//   wr_stb       one-cycle pulse per accepted register write
//   wr_addr      register index of the last write
//   wr_data      data of the last write
//   busy         addressed and in a transfer
//   write_count  accepted-write counter, wraps
//
// state       | meaning
// ST_IDLE     | bus free, waiting for START
// ST_ADDR     | shifting in address + r/w byte
// ST_ACK_ADDR | acknowledging our address
// ST_PTR      | shifting in register pointer
// ST_ACK_PTR  | acknowledging pointer
// ST_WR       | shifting in a data byte
// ST_ACK_WR   | acknowledging a data byte
// ST_RD       | driving a data byte out, MSB first
// ST_RD_ACK   | master's acknowledge bit after a read byte
// ST_IGNORE   | not addressed / read ended, wait for START or STOP
module i2c_cfg_responder
   import i2c_cfg_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEF,
   parameter int         ADDR_W    = 6,
   parameter logic [7:0] DEVICE_ID = DEVICE_ID_DEF,
   parameter int         DEGLITCH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scl_i,
   input  logic              sda_i,
   output logic              sda_oe,
   output logic              wr_stb,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic [7:0]        write_count
);

   localparam int DEPTH = 2**ADDR_W;

   logic              scl_rise, scl_fall, start_det, stop_det, sda_s;
   state_t            state, state_nxt;
   logic [7:0]        shift;
   logic [2:0]        cnt;
   logic [ADDR_W-1:0] ptr, ptr_inc;
   logic [7:0]        regs [DEPTH];
   logic              mbit;
   logic [7:0]        rx_byte, rd_cur, rd_inc;
   logic              byte_done, addr_hit;

   i2c_bus_sync #(.DEGLITCH(DEGLITCH)) u_sync (
      .clk       (clk),
      .reset     (reset),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   assign rx_byte   = {shift[6:0], sda_s};
   assign byte_done = scl_rise && (cnt == 3'd7);
   assign addr_hit  = (rx_byte[7:1] == DEV_ADDR);
   assign ptr_inc   = ptr + ADDR_W'(1);
   // Register 0 is the read-only identifier; its storage is never written.
   assign rd_cur    = (ptr == '0)     ? DEVICE_ID : regs[ptr];
   assign rd_inc    = (ptr_inc == '0) ? DEVICE_ID : regs[ptr_inc];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // In the ACK states sda_oe doubles as the phase: low = waiting for the
   // falling edge that starts the ACK, high = ACK in progress.
   always_comb begin
      state_nxt = state;
      if (stop_det) begin
         state_nxt = ST_IDLE;
      end else if (start_det) begin
         state_nxt = ST_ADDR;
      end else begin
         case (state)
            ST_ADDR:     if (byte_done) state_nxt = addr_hit ? ST_ACK_ADDR : ST_IGNORE;
            ST_ACK_ADDR: if (scl_fall && sda_oe) state_nxt = shift[0] ? ST_RD : ST_PTR;
            ST_PTR:      if (byte_done) state_nxt = ST_ACK_PTR;
            ST_ACK_PTR:  if (scl_fall && sda_oe) state_nxt = ST_WR;
            ST_WR:       if (byte_done) state_nxt = ST_ACK_WR;
            ST_ACK_WR:   if (scl_fall && sda_oe) state_nxt = ST_WR;
            ST_RD:       if (scl_fall && cnt == 3'd7) state_nxt = ST_RD_ACK;
            ST_RD_ACK:   if (scl_fall) state_nxt = (mbit == BIT_NACK) ? ST_IGNORE : ST_RD;
            ST_IDLE, ST_IGNORE: state_nxt = state;
            default:     state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift       <= '0;
         cnt         <= '0;
         ptr         <= '0;
         mbit        <= BIT_NACK;
         sda_oe      <= 1'b0;
         busy        <= 1'b0;
         wr_stb      <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         write_count <= '0;
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         wr_stb <= 1'b0;
         if (stop_det || start_det) begin
            cnt    <= '0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else begin
            case (state)
               ST_ADDR: if (scl_rise) begin
                  shift <= rx_byte;
                  cnt   <= cnt + 3'd1;
                  if (byte_done && addr_hit) busy <= 1'b1;
               end
               ST_PTR: if (scl_rise) begin
                  shift <= rx_byte;
                  cnt   <= cnt + 3'd1;
                  if (byte_done) ptr <= rx_byte[ADDR_W-1:0];
               end
               ST_WR: if (scl_rise) begin
                  shift <= rx_byte;
                  cnt   <= cnt + 3'd1;
                  if (byte_done) begin
                     if (ptr != '0) begin
                        regs[ptr]   <= rx_byte;
                        wr_stb      <= 1'b1;
                        wr_addr     <= ptr;
                        wr_data     <= rx_byte;
                        write_count <= write_count + 8'd1;
                     end
                     ptr <= ptr_inc;
                  end
               end
               ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_WR: if (scl_fall) begin
                  if (!sda_oe) begin
                     sda_oe <= 1'b1;
                  end else if (state == ST_ACK_ADDR && shift[0]) begin
                     shift  <= rd_cur;
                     sda_oe <= ~rd_cur[7];
                  end else begin
                     sda_oe <= 1'b0;
                  end
               end
               // Rotate rather than shift so shift[6] is always the next bit out.
               ST_RD: if (scl_fall) begin
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     sda_oe <= 1'b0;
                  end else begin
                     shift  <= {shift[6:0], shift[7]};
                     sda_oe <= ~shift[6];
                  end
               end
               ST_RD_ACK: begin
                  if (scl_rise) mbit <= sda_s;
                  if (scl_fall && mbit == BIT_ACK) begin
                     ptr    <= ptr_inc;
                     shift  <= rd_inc;
                     sda_oe <= ~rd_inc[7];
                  end
               end
               ST_IGNORE: begin
                  sda_oe <= 1'b0;
                  busy   <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
